// File: rtl/tlb_refill_ctrl_if.sv
// Miss / page-walk / TLB-write signal bundle for the TLB refill controller.
// The slave modport is the controller's view; master is the surrounding MMU side.
interface tlb_refill_ctrl_if #(
  parameter int VPN_W = 27,
  parameter int PTE_W = 64
);
  logic             MissValid;
  logic [VPN_W-1:0] MissVPN;
  logic             MissReady;
  logic             PTW_ReqValid;
  logic [VPN_W-1:0] PTW_ReqVPN;
  logic             PTW_ReqReady;
  logic             PTW_RespValid;
  logic [PTE_W-1:0] PTW_RespPTE;
  logic             PTW_RespFault;
  logic [4:0]       LRU_Way;
  logic             Flush;
  logic             WrEn;
  logic [4:0]       WrWay;
  logic [VPN_W-1:0] WrVPN;
  logic [PTE_W-1:0] WrPTE;
  logic             WriteAccess;
  logic [4:0]       WriteWay;
  logic [31:0]      ValidVec;
  logic             RefillDone;
  logic             RefillFault;
  logic             Busy;

  modport slave (
    input  MissValid, MissVPN, PTW_ReqReady, PTW_RespValid, PTW_RespPTE,
           PTW_RespFault, LRU_Way, Flush,
    output MissReady, PTW_ReqValid, PTW_ReqVPN, WrEn, WrWay, WrVPN, WrPTE,
           WriteAccess, WriteWay, ValidVec, RefillDone, RefillFault, Busy
  );

  modport master (
    output MissValid, MissVPN, PTW_ReqReady, PTW_RespValid, PTW_RespPTE,
           PTW_RespFault, LRU_Way, Flush,
    input  MissReady, PTW_ReqValid, PTW_ReqVPN, WrEn, WrWay, WrVPN, WrPTE,
           WriteAccess, WriteWay, ValidVec, RefillDone, RefillFault, Busy
  );
endinterface

// File: rtl/tlb_refill_ctrl.sv
// Single-outstanding TLB miss refill: walk request, PTE capture, victim pick,
// one-cycle array write, and ownership of the per-way valid bits (incl. flush).
module tlb_refill_ctrl #(
  parameter int VPN_W = 27,
  parameter int PTE_W = 64,
  parameter int NWAYS = 32
) (
  input  logic             clk,
  input  logic             rst,
  tlb_refill_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_e;

  state_e           state_q, state_d;
  logic [VPN_W-1:0] vpn_q;
  logic [PTE_W-1:0] pte_q;
  logic [4:0]       way_q;
  logic [NWAYS-1:0] valid_q, valid_d;
  logic             stale_q, stale_d;
  logic             done_q, fault_q;

  logic             accept, resp_ok, resp_flt, wr_fire;
  logic [NWAYS-1:0] valid_eff;
  logic [4:0]       victim;

  assign accept   = (state_q == S_IDLE) && bus.MissValid && !bus.Flush;
  assign resp_ok  = (state_q == S_WAIT) && bus.PTW_RespValid && !bus.PTW_RespFault;
  assign resp_flt = (state_q == S_WAIT) && bus.PTW_RespValid && bus.PTW_RespFault;
  assign wr_fire  = (state_q == S_WRITE) && !bus.Flush;

  // Victim is chosen against the valid bits as a same-cycle flush leaves them.
  always_comb begin
    valid_eff = bus.Flush ? '0 : valid_q;
    victim    = bus.LRU_Way;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!valid_eff[i]) victim = 5'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_REQ;
      S_REQ:   if (bus.PTW_ReqReady) state_d = S_WAIT;
      // A response that arrives after (or with) a flush is consumed but dropped.
      S_WAIT:  if (bus.PTW_RespValid)
                 state_d = (bus.PTW_RespFault || stale_q || bus.Flush) ? S_IDLE : S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stale_d = 1'b0;
    if (state_d != S_IDLE)
      stale_d = stale_q || (bus.Flush && (state_q == S_REQ || state_q == S_WAIT));
    valid_d = valid_q;
    if (bus.Flush)   valid_d = '0;
    else if (wr_fire) valid_d = valid_q | (NWAYS'(1) << way_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpn_q   <= '0;
      pte_q   <= '0;
      way_q   <= '0;
      valid_q <= '0;
      stale_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (accept) vpn_q <= bus.MissVPN;
      if (resp_ok) begin
        pte_q <= bus.PTW_RespPTE;
        way_q <= victim;
      end
      valid_q <= valid_d;
      stale_q <= stale_d;
      done_q  <= wr_fire;
      fault_q <= resp_flt;
    end
  end

  always_comb begin
    bus.MissReady    = (state_q == S_IDLE) && !bus.Flush;
    bus.PTW_ReqValid = (state_q == S_REQ);
    bus.PTW_ReqVPN   = vpn_q;
    bus.WrEn         = wr_fire;
    bus.WrWay        = way_q;
    bus.WrVPN        = vpn_q;
    bus.WrPTE        = pte_q;
    bus.WriteAccess  = wr_fire;
    bus.WriteWay     = way_q;
    bus.ValidVec     = 32'(valid_q);
    bus.RefillDone   = done_q;
    bus.RefillFault  = fault_q;
    bus.Busy         = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Directed bench for tlb_refill_ctrl; expected writes are queued when a response
// is driven and retired by a monitor whenever the array write strobe fires.
module tb_tlb_refill_ctrl;
  localparam int VPN_W = 27;
  localparam int PTE_W = 64;

  typedef struct packed {
    logic [4:0]       way;
    logic [VPN_W-1:0] vpn;
    logic [PTE_W-1:0] pte;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  wr_t  sb_q[$];
  logic [31:0] mvalid = '0;

  tlb_refill_ctrl_if #(.VPN_W(VPN_W), .PTE_W(PTE_W)) bus ();

  tlb_refill_ctrl #(.VPN_W(VPN_W), .PTE_W(PTE_W), .NWAYS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.WrEn || bus.WriteAccess) begin
        check("wa_eq_wren", 64'(bus.WriteAccess), 64'(bus.WrEn));
        check("ww_eq_wrway", 64'(bus.WriteWay), 64'(bus.WrWay));
        if (sb_q.size() == 0) check("unexpected_write", 64'(1), 64'(0));
        else begin
          wr_t e;
          e = sb_q.pop_front();
          check("sb_way", 64'(bus.WrWay), 64'(e.way));
          check("sb_vpn", 64'(bus.WrVPN), 64'(e.vpn));
          check("sb_pte", 64'(bus.WrPTE), 64'(e.pte));
        end
      end
      if (bus.RefillDone && bus.RefillFault) check("done_fault_excl", 64'(1), 64'(0));
    end
  end

  function automatic logic [4:0] pick(input logic [31:0] v, input logic [4:0] lru);
    for (int i = 0; i < 32; i++) if (!v[i]) return 5'(i);
    return lru;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [VPN_W-1:0] vpn);
    bus.MissVPN   = vpn;
    bus.MissValid = 1'b1;
    #1;
    check("miss_ready", 64'(bus.MissReady), 64'(1));
    step();
    bus.MissValid = 1'b0;
    check("req_valid", 64'(bus.PTW_ReqValid), 64'(1));
    check("req_vpn", 64'(bus.PTW_ReqVPN), 64'(vpn));
  endtask

  task automatic handshake(input int n);
    repeat (n) begin
      step();
      check("req_hold", 64'(bus.PTW_ReqValid), 64'(1));
    end
    bus.PTW_ReqReady = 1'b1;
    step();
    bus.PTW_ReqReady = 1'b0;
    check("wait_busy", 64'(bus.Busy), 64'(1));
    check("wait_noreq", 64'(bus.PTW_ReqValid), 64'(0));
  endtask

  task automatic respond(input int n, input logic [PTE_W-1:0] pte, input logic flt);
    repeat (n) step();
    bus.PTW_RespValid = 1'b1;
    bus.PTW_RespPTE   = pte;
    bus.PTW_RespFault = flt;
    step();
    bus.PTW_RespValid = 1'b0;
    bus.PTW_RespFault = 1'b0;
  endtask

  task automatic refill(input logic [VPN_W-1:0] vpn, input logic [PTE_W-1:0] pte,
                        input int rd, input int wd);
    logic [4:0] exp;
    exp = pick(mvalid, bus.LRU_Way);
    accept(vpn);
    handshake(rd);
    sb_q.push_back('{way: exp, vpn: vpn, pte: pte});
    respond(wd, pte, 1'b0);
    check("wr_en", 64'(bus.WrEn), 64'(1));
    check("wr_access", 64'(bus.WriteAccess), 64'(1));
    check("wr_way", 64'(bus.WrWay), 64'(exp));
    step();
    mvalid[exp] = 1'b1;
    check("refill_done", 64'(bus.RefillDone), 64'(1));
    check("valid_vec", 64'(bus.ValidVec), 64'(mvalid));
    check("back_idle", 64'(bus.Busy), 64'(0));
  endtask

  initial begin
    bus.MissValid = 0; bus.MissVPN = '0; bus.PTW_ReqReady = 0; bus.PTW_RespValid = 0;
    bus.PTW_RespPTE = '0; bus.PTW_RespFault = 0; bus.LRU_Way = 5'd17; bus.Flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.Busy), 64'(0));
    check("rst_valid", 64'(bus.ValidVec), 64'(0));
    check("rst_wren", 64'(bus.WrEn), 64'(0));
    check("rst_req", 64'(bus.PTW_ReqValid), 64'(0));
    check("rst_done", 64'(bus.RefillDone), 64'(0));
    rst = 1'b1;
    step();
    check("rst_missready", 64'(bus.MissReady), 64'(1));

    // First refill: ready on 2nd request cycle, response 3 cycles into WAIT.
    refill(27'h1234, 64'hABCD, 1, 3);
    check("first_valid", 64'(bus.ValidVec), 64'h1);

    for (int i = 1; i < 32; i++)
      refill(27'(32'h100 + i), {$urandom, $urandom}, i % 3, i % 4);
    check("all_valid", 64'(bus.ValidVec), 64'hFFFF_FFFF);
    refill(27'h999, 64'h5A5A_0000_1111, 0, 1);
    check("lru_valid", 64'(bus.ValidVec), 64'hFFFF_FFFF);

    // Walk fault.
    accept(27'h55);
    handshake(0);
    respond(2, 64'h0, 1'b1);
    check("flt_pulse", 64'(bus.RefillFault), 64'(1));
    check("flt_nowr", 64'(bus.WrEn), 64'(0));
    check("flt_ready", 64'(bus.MissReady), 64'(1));
    step();
    check("flt_once", 64'(bus.RefillFault), 64'(0));
    check("flt_valid", 64'(bus.ValidVec), 64'hFFFF_FFFF);

    // Flush while waiting on the walker: response is dropped.
    accept(27'h66);
    handshake(0);
    bus.Flush = 1'b1;
    step();
    bus.Flush = 1'b0;
    mvalid = '0;
    check("fw_valid", 64'(bus.ValidVec), 64'(0));
    check("fw_busy", 64'(bus.Busy), 64'(1));
    respond(1, 64'h77, 1'b0);
    check("fw_nowr", 64'(bus.WrEn), 64'(0));
    check("fw_idle", 64'(bus.Busy), 64'(0));
    step();
    check("fw_nodone", 64'(bus.RefillDone), 64'(0));

    // Flush coincident with WRITE, then a miss held across the flush.
    accept(27'h88);
    handshake(0);
    respond(0, 64'h99, 1'b0);
    check("fwr_pre", 64'(bus.WrEn), 64'(1));
    sb_q.delete();
    bus.Flush = 1'b1;
    #1;
    check("fwr_wren", 64'(bus.WrEn), 64'(0));
    check("fwr_wa", 64'(bus.WriteAccess), 64'(0));
    bus.MissValid = 1'b1;
    bus.MissVPN   = 27'hAA;
    step();
    check("fwr_valid", 64'(bus.ValidVec), 64'(0));
    check("fwr_nodone", 64'(bus.RefillDone), 64'(0));
    check("fwr_idle", 64'(bus.Busy), 64'(0));
    check("fl_noready", 64'(bus.MissReady), 64'(0));
    step();
    check("fl_notaken", 64'(bus.Busy), 64'(0));
    bus.Flush = 1'b0;
    #1;
    check("fl_ready", 64'(bus.MissReady), 64'(1));
    step();
    bus.MissValid = 1'b0;
    check("fl_taken", 64'(bus.Busy), 64'(1));
    check("fl_vpn", 64'(bus.PTW_ReqVPN), 64'h0AA);
    handshake(0);

    // Async reset in WAIT; a late response afterwards must be ignored.
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy", 64'(bus.Busy), 64'(0));
    check("ar_req", 64'(bus.PTW_ReqValid), 64'(0));
    check("ar_vpn", 64'(bus.WrVPN), 64'(0));
    check("ar_valid", 64'(bus.ValidVec), 64'(0));
    check("ar_ready", 64'(bus.MissReady), 64'(1));
    step();
    rst = 1'b1;
    step();
    bus.PTW_RespValid = 1'b1;
    bus.PTW_RespPTE   = 64'hDEAD;
    step();
    bus.PTW_RespValid = 1'b0;
    check("late_idle", 64'(bus.Busy), 64'(0));
    check("late_nowr", 64'(bus.WrEn), 64'(0));
    step();
    check("late_nodone", 64'(bus.RefillDone), 64'(0));
    check("late_valid", 64'(bus.ValidVec), 64'(0));
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
